// File: rtl/mprj_io_cfg_pkg.sv
// rtl/mprj_io_cfg_pkg.sv - shared constants, config word layout and FSM states for the IO config loader
//
// Purpose: common definitions for mprj_io_cfg_loader and its serial clock generator.
// Ports: none (package).

package mprj_io_cfg_pkg;

    // Pads in the user IO chain and config bits per pad.
    localparam int MPRJ_IO_PADS = 38;
    localparam int CFG_BITS     = 13;

    // Field offsets inside one pad config word.
    // enh and hldh_n share a bit: the pad needs them released together,
    // so one bit drives both.
    localparam int CFG_MGMT_EN_OFS     = 0;
    localparam int CFG_OEB_OFS         = 1;
    localparam int CFG_HLDH_N_OFS      = 2;
    localparam int CFG_ENH_OFS         = 2;
    localparam int CFG_INP_DIS_OFS     = 3;
    localparam int CFG_IB_MODE_SEL_OFS = 4;
    localparam int CFG_ANALOG_EN_OFS   = 5;
    localparam int CFG_ANALOG_SEL_OFS  = 6;
    localparam int CFG_ANALOG_POL_OFS  = 7;
    localparam int CFG_SLOW_SEL_OFS    = 8;
    localparam int CFG_VTRIP_SEL_OFS   = 9;
    localparam int CFG_DM_OFS          = 10;
    localparam int CFG_DM_W            = 3;

    // Loader sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SHIFT = 3'd2,
        ST_LOAD  = 3'd3,
        ST_DONE  = 3'd4
    } cfg_state_t;

endpackage

// File: rtl/mprj_io_cfg_sclk_gen.sv
// rtl/mprj_io_cfg_sclk_gen.sv - divided serial clock phase counter for the IO config chain
//
// Purpose: counts 2*CLK_DIV wb_clk cycles per serial bit while enabled.
// Ports:
//   i_clk          system clock
//   i_rst          asynchronous active-high reset
//   i_en           run the phase counter; when low the counter is held at 0
//   o_phase_rise   high in the last cycle of the low phase (clock rises next)
//   o_bit_end      high in the last cycle of the high phase (bit finishes next)

module mprj_io_cfg_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_phase_rise,
    output logic o_bit_end
);

    localparam int CNT_W = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] RISE_AT = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] END_AT  = CNT_W'(2 * CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (!i_en || (r_cnt == END_AT)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_phase_rise = i_en && (r_cnt == RISE_AT);
    assign o_bit_end    = i_en && (r_cnt == END_AT);

endmodule

// File: rtl/mprj_io_cfg_loader.sv
// rtl/mprj_io_cfg_loader.sv - serializes per-pad config words into the user IO config shift chain
//
// Purpose: on xfer_start, fetch one word per pad (highest index first), shift
// it MSB first on a divided serial clock, then pulse serial_load once.
// Ports:
//   wb_clk_i         system clock
//   wb_rst_i         asynchronous active-high reset
//   xfer_start       single-cycle request to load the whole chain
//   xfer_busy        high while a transfer is in progress
//   xfer_done        one-cycle pulse when a transfer completes
//   cfg_idx          pad index whose word is being fetched
//   cfg_word         config word for cfg_idx (combinational read)
//   serial_clock     chain shift clock
//   serial_data_out  chain shift data
//   serial_load      chain parallel-load strobe
//   serial_resetn    chain reset, active low

module mprj_io_cfg_loader
    import mprj_io_cfg_pkg::*;
#(
    parameter int NUM_PADS = MPRJ_IO_PADS,
    parameter int CFG_BITS = mprj_io_cfg_pkg::CFG_BITS,
    parameter int CLK_DIV  = 2,
    localparam int IDX_W   = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                xfer_start,
    output logic                xfer_busy,
    output logic                xfer_done,
    output logic [IDX_W-1:0]    cfg_idx,
    input  logic [CFG_BITS-1:0] cfg_word,
    output logic                serial_clock,
    output logic                serial_data_out,
    output logic                serial_load,
    output logic                serial_resetn
);

    localparam int BIT_W = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_PADS - 1);
    localparam logic [BIT_W-1:0] BIT_TOP = BIT_W'(CFG_BITS - 1);

    cfg_state_t          r_state;
    cfg_state_t          w_state_next;
    logic [CFG_BITS-1:0] r_shift;
    logic [CFG_BITS-1:0] w_shift_next;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic                r_busy;
    logic                r_done;
    logic                r_sclk;
    logic                r_sdo;
    logic                r_load;
    logic                r_resetn;
    logic                w_sclk_en;
    logic                w_phase_rise;
    logic                w_bit_end;
    logic                w_last_bit;

    // The phase counter also times the load strobe: it wraps to 0 on the
    // last bit, so LOAD ends on the first phase_rise, CLK_DIV cycles later.
    assign w_sclk_en = (r_state == ST_SHIFT) || (r_state == ST_LOAD);

    mprj_io_cfg_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .i_clk        (wb_clk_i),
        .i_rst        (wb_rst_i),
        .i_en         (w_sclk_en),
        .o_phase_rise (w_phase_rise),
        .o_bit_end    (w_bit_end)
    );

    assign w_last_bit = w_bit_end && (r_bit_cnt == '0);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        case (r_state)
            ST_IDLE: begin
                if (xfer_start) begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_shift_next = cfg_word;
                w_state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_bit_end) begin
                    w_shift_next = r_shift << 1;
                end
                if (w_last_bit) begin
                    w_state_next = (r_idx == '0) ? ST_LOAD : ST_FETCH;
                end
            end
            ST_LOAD: begin
                if (w_phase_rise) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state view so each one is valid
    // in the same cycle as the state it belongs to.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_idx     <= IDX_TOP;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sclk    <= 1'b0;
            r_sdo     <= 1'b0;
            r_load    <= 1'b0;
            r_resetn  <= 1'b0;
        end else begin
            r_resetn <= 1'b1;
            r_shift  <= w_shift_next;

            if (r_state == ST_FETCH) begin
                r_bit_cnt <= BIT_TOP;
            end else if ((r_state == ST_SHIFT) && w_bit_end && (r_bit_cnt != '0)) begin
                r_bit_cnt <= r_bit_cnt - 1'b1;
            end

            // The index only moves on the edge leaving a pad's last bit, so it
            // stays put across that pad's FETCH and SHIFT.
            if ((r_state == ST_IDLE) || (r_state == ST_DONE)) begin
                r_idx <= IDX_TOP;
            end else if ((r_state == ST_SHIFT) && w_last_bit && (r_idx != '0)) begin
                r_idx <= r_idx - 1'b1;
            end

            r_busy <= (w_state_next == ST_FETCH) || (w_state_next == ST_SHIFT) ||
                      (w_state_next == ST_LOAD);
            r_done <= (w_state_next == ST_DONE);
            r_load <= (w_state_next == ST_LOAD);

            if (r_state != ST_SHIFT) begin
                r_sclk <= 1'b0;
            end else if (w_phase_rise) begin
                r_sclk <= 1'b1;
            end else if (w_bit_end) begin
                r_sclk <= 1'b0;
            end

            // Data follows the shift register MSB, which only moves on the
            // edge that also drops the serial clock.
            r_sdo <= (w_state_next == ST_SHIFT) ? w_shift_next[CFG_BITS-1] : 1'b0;
        end
    end

    assign xfer_busy       = r_busy;
    assign xfer_done       = r_done;
    assign cfg_idx         = r_idx;
    assign serial_clock    = r_sclk;
    assign serial_data_out = r_sdo;
    assign serial_load     = r_load;
    assign serial_resetn   = r_resetn;

endmodule

// File: tb/tb_mprj_io_cfg_loader.sv
// tb/tb_mprj_io_cfg_loader.sv - self-checking bench for mprj_io_cfg_loader

module tb_mprj_io_cfg_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] start = 3'b000;

    wire  [2:0] sclk;
    wire  [2:0] sdo;
    wire  [2:0] load;
    wire  [2:0] busy;
    wire  [2:0] done;
    wire  [2:0] rstn;
    wire        idx_a;
    wire  [5:0] idx_b;
    wire        idx_c;

    logic [2:0]  words_a [2];
    logic [12:0] words_b [38];
    logic [2:0]  words_c [2];

    wire  [2:0]  word_a = words_a[idx_a];
    wire  [12:0] word_b = words_b[idx_b];
    wire  [2:0]  word_c = words_c[idx_c];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mprj_io_cfg_loader #(.NUM_PADS(2), .CFG_BITS(3), .CLK_DIV(1)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .xfer_start(start[0]),
        .xfer_busy(busy[0]), .xfer_done(done[0]), .cfg_idx(idx_a), .cfg_word(word_a),
        .serial_clock(sclk[0]), .serial_data_out(sdo[0]), .serial_load(load[0]),
        .serial_resetn(rstn[0]));

    mprj_io_cfg_loader dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .xfer_start(start[1]),
        .xfer_busy(busy[1]), .xfer_done(done[1]), .cfg_idx(idx_b), .cfg_word(word_b),
        .serial_clock(sclk[1]), .serial_data_out(sdo[1]), .serial_load(load[1]),
        .serial_resetn(rstn[1]));

    mprj_io_cfg_loader #(.NUM_PADS(2), .CFG_BITS(3), .CLK_DIV(3)) dut_c (
        .wb_clk_i(clk), .wb_rst_i(rst), .xfer_start(start[2]),
        .xfer_busy(busy[2]), .xfer_done(done[2]), .cfg_idx(idx_c), .cfg_word(word_c),
        .serial_clock(sclk[2]), .serial_data_out(sdo[2]), .serial_load(load[2]),
        .serial_resetn(rstn[2]));

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int get_word(input int u, input int p);
        case (u)
            0:       return int'(words_a[p[0]]);
            1:       return int'(words_b[p[5:0]]);
            default: return int'(words_c[p[0]]);
        endcase
    endfunction

    task automatic randomize_words(input int u);
        for (int p = 0; p < 38; p++) begin
            if (u == 1) words_b[p] = 13'($urandom);
            else if (p < 2 && u == 0) words_a[p] = 3'($urandom);
            else if (p < 2) words_c[p] = 3'($urandom);
        end
    endtask

    // Reference: the chain sees pads high-to-low, each MSB first, one bit per
    // serial clock rise; done arrives after np*(fetch + 2*cd*cb) + cd + 1 cycles.
    task automatic run_xfer(input int u, input int np, input int cb, input int cd,
                            input int repulse);
        int   lat;
        logic expq[$];
        logic got[$];
        int   bit_err, busy_err, ovl, hold_err, phase_err, run;
        int   load_first, load_cnt, done_first, done_cnt;
        logic s, d, prev_s, prev_d;
        string pfx;
        pfx = $sformatf("u%0d_", u);
        lat = 1 + np * (1 + 2 * cd * cb) + cd;
        for (int p = np - 1; p >= 0; p--)
            for (int b = cb - 1; b >= 0; b--)
                expq.push_back(((get_word(u, p) >> b) & 1) != 0);
        bit_err = 0; busy_err = 0; ovl = 0; hold_err = 0; phase_err = 0;
        load_first = -1; load_cnt = 0; done_first = -1; done_cnt = 0;
        @(negedge clk);
        start[u] = 1'b1;
        prev_s = sclk[u];
        prev_d = sdo[u];
        run = 0;
        for (int c = 1; c <= lat + 3; c++) begin
            @(negedge clk);
            start[u] = (c == repulse);
            s = sclk[u];
            d = sdo[u];
            if (s != prev_s) begin
                if (prev_s) begin
                    if (run != cd) phase_err++;
                end else if (run != (((got.size() % cb) == 0) ? cd + 1 : cd)) begin
                    phase_err++;
                end
                run = 1;
            end else begin
                run++;
            end
            if (s && !prev_s) got.push_back(d);
            if (s && (d !== prev_d)) hold_err++;
            if (s && load[u]) ovl++;
            if (load[u]) begin
                load_cnt++;
                if (load_first < 0) load_first = c;
            end
            if (done[u]) begin
                done_cnt++;
                if (done_first < 0) done_first = c;
            end
            if (busy[u] !== (c < lat)) busy_err++;
            prev_s = s;
            prev_d = d;
        end
        start[u] = 1'b0;
        for (int i = 0; i < expq.size() && i < got.size(); i++)
            if (got[i] !== expq[i]) bit_err++;
        check({pfx, "stream_len"}, got.size(), np * cb);
        check({pfx, "stream_bits"}, bit_err, 0);
        check({pfx, "load_first"}, load_first, lat - cd);
        check({pfx, "load_len"}, load_cnt, cd);
        check({pfx, "done_cycle"}, done_first, lat);
        check({pfx, "done_cnt"}, done_cnt, 1);
        check({pfx, "busy_window"}, busy_err, 0);
        check({pfx, "clk_load_overlap"}, ovl, 0);
        check({pfx, "data_hold"}, hold_err, 0);
        check({pfx, "phase_len"}, phase_err, 0);
    endtask

    initial begin
        int lc;
        int dc;
        int bc;
        words_a[1] = 3'b101;
        words_a[0] = 3'b011;
        randomize_words(1);
        randomize_words(2);

        // reset state
        @(negedge clk);
        check("rst_outputs", int'({sclk, sdo, load, busy, done, rstn}), 0);
        check("rst_idx_a", int'(idx_a), 1);
        check("rst_idx_b", int'(idx_b), 37);
        check("rst_idx_c", int'(idx_c), 1);
        rst = 1'b0;
        @(negedge clk);
        check("release_resetn", int'(rstn), 7);
        check("release_idle_outputs", int'({sclk, sdo, load, busy, done}), 0);

        // fixed words: stream 1,0,1,0,1,1; load at k+15; done at k+16
        run_xfer(0, 2, 3, 1, 0);
        check("u0_idx_after", int'(idx_a), 1);

        // random words, start re-pulsed mid-shift
        randomize_words(0);
        run_xfer(0, 2, 3, 1, 5);

        // CLK_DIV=3: re-pulse mid-shift, then re-pulse in the DONE cycle
        run_xfer(2, 2, 3, 3, 7);
        randomize_words(2);
        run_xfer(2, 2, 3, 3, 42);

        // default parameters: 494 bits, done 2017 cycles after the start edge
        run_xfer(1, 38, 13, 2, 1000);
        check("u1_idx_after", int'(idx_b), 37);

        // reset during pad 0 shift (cycle k+10 is a high phase of pad 0)
        randomize_words(0);
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (9) @(negedge clk);
        check("u0_pre_rst_sclk", int'(sclk[0]), 1);
        check("u0_pre_rst_idx", int'(idx_a), 0);
        rst = 1'b1;
        #1;
        check("async_rst_outputs", int'({sclk[0], sdo[0], load[0], busy[0], done[0], rstn[0]}), 0);
        check("async_rst_idx", int'(idx_a), 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        lc = 0; dc = 0; bc = 0;
        repeat (30) begin
            @(negedge clk);
            lc += int'(load[0]);
            dc += int'(done[0]);
            bc += int'(busy[0]);
        end
        check("post_rst_load", lc, 0);
        check("post_rst_done", dc, 0);
        check("post_rst_busy", bc, 0);
        check("post_rst_resetn", int'(rstn), 7);

        // normal operation after the aborted transfer
        randomize_words(0);
        run_xfer(0, 2, 3, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
